// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared widths and the queued late-write entry type for the
// general register file write-back arbiter.
//   REG_AW  register address width
//   DATA_W  data / PC width
//   NREG    number of architectural registers (width of the busy mask)
package grf_wb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
    logic              valid;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// wb_fifo: small FIFO of pending late writes with per-entry invalidate by
// register address (used when a younger pipeline write supersedes a queued one).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_data   enqueue one entry (caller guarantees !full)
//   pop               dequeue head (caller guarantees !empty)
//   inv, inv_wa       drop every live entry targeting inv_wa
//   head              current head entry (valid=0 means superseded)
//   full, empty       occupancy flags
//   hit               some live entry targets inv_wa
module wb_fifo
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wb_entry_t         push_data,
  input  logic              pop,
  input  logic              inv,
  input  logic [REG_AW-1:0] inv_wa,
  output wb_entry_t         head,
  output logic              full,
  output logic              empty,
  output logic              hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // valid is cleared on pop, so valid alone marks a live, unsuperseded entry
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].valid && (mem[i].wa == inv_wa)) hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (inv)
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].valid && (mem[i].wa == inv_wa)) mem[i].valid <= 1'b0;
      // a same-cycle push is younger than the superseding write, so it stays live
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges in-order pipeline W-stage writes and out-of-order
// late writes onto the register file's single write port, and tracks a busy
// mask of registers with outstanding late writes for the hazard unit.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   p_we/p_wa/p_wd/p_pc        pipeline write (highest priority, zero latency)
//   iss_valid/iss_wa           late-writing instruction issued (sets busy)
//   l_valid/l_ready/l_wa/l_wd/l_pc  late write handshake
//   WE/WA/WD/PC                register file write port
//   busy                       per-register outstanding late write mask
// Optional: define GRF_WB_TRACE_EN for a per-write simulation trace.
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_we,
  input  logic [REG_AW-1:0] p_wa,
  input  logic [DATA_W-1:0] p_wd,
  input  logic [DATA_W-1:0] p_pc,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_wa,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [REG_AW-1:0] l_wa,
  input  logic [DATA_W-1:0] l_wd,
  input  logic [DATA_W-1:0] l_pc,
  output logic              WE,
  output logic [REG_AW-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] PC,
  output logic [NREG-1:0]   busy
);

  logic            p_act;
  logic            l_nz;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            head_we;
  logic            late_we;
  logic            hit;
  logic            full;
  logic            empty;
  wb_entry_t       head;
  wb_entry_t       push_data;
  logic [NREG-1:0] busy_nxt;

  assign p_act   = p_we && (p_wa != '0);
  assign l_nz    = (l_wa != '0);
  assign l_ready = !full;
  assign bypass  = empty && !p_act && l_valid && l_nz;
  // late writes to r0 are accepted but never queued
  assign push    = l_valid && !full && l_nz && !bypass;
  // a superseded head leaves without using the write port, so it may pop
  // even while the pipeline owns the port
  assign pop     = !empty && !(p_act && head.valid);
  assign head_we = !empty && head.valid && !p_act;
  assign late_we = rst_n && (head_we || bypass);

  assign push_data = '{wa: l_wa, wd: l_wd, pc: l_pc, valid: 1'b1};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .inv       (p_act),
    .inv_wa    (p_wa),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .hit       (hit)
  );

  // rst_n gates the port so a pipeline request held during reset writes nothing
  always_comb begin
    WE = 1'b0;
    WA = '0;
    WD = '0;
    PC = '0;
    if (rst_n) begin
      if (p_act) begin
        WE = 1'b1; WA = p_wa;    WD = p_wd;    PC = p_pc;
      end else if (head_we) begin
        WE = 1'b1; WA = head.wa; WD = head.wd; PC = head.pc;
      end else if (bypass) begin
        WE = 1'b1; WA = l_wa;    WD = l_wd;    PC = l_pc;
      end
    end
  end

  // clears first, issue set last so a coincident issue of the same register wins
  always_comb begin
    busy_nxt = busy;
    if (late_we) busy_nxt[WA] = 1'b0;
    if (p_act && hit) busy_nxt[p_wa] = 1'b0;
    if (iss_valid && (iss_wa != '0)) busy_nxt[iss_wa] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (WE) $display("%d@%h: $%d <= %h", $time, PC, WA, WD);
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_wa;
  logic [31:0] l_wd;
  logic [31:0] l_pc;
  logic        WE;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] busy;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf [32];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_we      (p_we),
    .p_wa      (p_wa),
    .p_wd      (p_wd),
    .p_pc      (p_pc),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .l_valid   (l_valid),
    .l_ready   (l_ready),
    .l_wa      (l_wa),
    .l_wd      (l_wd),
    .l_pc      (l_pc),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .PC        (PC),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expw(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    exp_t e;
    e.wa = wa; e.wd = wd; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // compare the write port against the scoreboard, away from the clock edge
  task automatic mon();
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("we", {31'b0, WE}, 32'd1);
      if (WE === 1'b1) begin
        chk("wa", {27'b0, WA}, {27'b0, e.wa});
        chk("wd", WD, e.wd);
        chk("pc", PC, e.pc);
        rf[WA] = WD;
      end
    end else begin
      chk("no_we", {31'b0, WE}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] wa);
    iss_valid = 1'b1; iss_wa = wa;
    tick();
    iss_valid = 1'b0; iss_wa = '0;
  endtask

  task automatic pipe(input logic en, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    p_we = en; p_wa = wa; p_wd = wd; p_pc = pc;
  endtask

  task automatic late(input logic en, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    l_valid = en; l_wa = wa; l_wd = wd; l_pc = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_wa = '0;
    pipe(1'b1, 5'd5, 32'hDEAD, 32'h10);
    late(1'b0, '0, '0, '0);

    // reset: pipeline request held during reset must not write
    repeat (2) tick();
    chk("rst_busy", busy, 32'h0);
    chk("rst_lready", {31'b0, l_ready}, 32'd1);
    chk("rst_wa", {27'b0, WA}, 32'h0);
    chk("rst_wd", WD, 32'h0);
    chk("rst_pc", PC, 32'h0);
    rst_n = 1'b1;

    // pipeline only
    pipe(1'b1, 5'd5, 32'h1234, 32'h100);
    expw(5'd5, 32'h1234, 32'h100);
    tick();
    pipe(1'b1, 5'd0, 32'h5555, 32'h104);
    tick();
    pipe(1'b0, '0, '0, '0);

    // bypass
    issue(5'd8);
    chk("byp_busy_set", busy, 32'h0000_0100);
    late(1'b1, 5'd8, 32'hAA, 32'h200);
    chk("byp_lready", {31'b0, l_ready}, 32'd1);
    expw(5'd8, 32'hAA, 32'h200);
    tick();
    late(1'b0, '0, '0, '0);
    chk("byp_busy_clr", busy, 32'h0);

    // issue and retire of the same register coincide: set wins
    issue(5'd8);
    iss_valid = 1'b1; iss_wa = 5'd8;
    late(1'b1, 5'd8, 32'hAB, 32'h204);
    expw(5'd8, 32'hAB, 32'h204);
    tick();
    iss_valid = 1'b0; iss_wa = '0;
    chk("coinc_busy", busy, 32'h0000_0100);
    late(1'b1, 5'd8, 32'hAC, 32'h208);
    expw(5'd8, 32'hAC, 32'h208);
    tick();
    late(1'b0, '0, '0, '0);
    chk("coinc_clr", busy, 32'h0);

    // contention
    issue(5'd9);
    issue(5'd10);
    pipe(1'b1, 5'd3, 32'h33, 32'h300);
    late(1'b1, 5'd9, 32'h99, 32'h400);
    chk("cont_lready0", {31'b0, l_ready}, 32'd1);
    expw(5'd3, 32'h33, 32'h300);
    tick();
    pipe(1'b1, 5'd4, 32'h44, 32'h304);
    late(1'b1, 5'd10, 32'hA0, 32'h404);
    chk("cont_lready1", {31'b0, l_ready}, 32'd1);
    expw(5'd4, 32'h44, 32'h304);
    tick();
    pipe(1'b1, 5'd6, 32'h66, 32'h308);
    late(1'b1, 5'd11, 32'hB0, 32'h408);
    chk("cont_lready_full", {31'b0, l_ready}, 32'd0);
    expw(5'd6, 32'h66, 32'h308);
    tick();
    pipe(1'b0, '0, '0, '0);
    late(1'b0, '0, '0, '0);
    chk("cont_busy", busy, 32'h0000_0600);
    expw(5'd9, 32'h99, 32'h400);
    tick();
    expw(5'd10, 32'hA0, 32'h404);
    tick();
    chk("cont_busy_clr", busy, 32'h0);
    chk("cont_lready_end", {31'b0, l_ready}, 32'd1);

    // supersede
    issue(5'd12);
    pipe(1'b1, 5'd1, 32'h11, 32'h500);
    late(1'b1, 5'd12, 32'h55, 32'h600);
    expw(5'd1, 32'h11, 32'h500);
    tick();
    late(1'b0, '0, '0, '0);
    chk("sup_busy_set", busy, 32'h0000_1000);
    pipe(1'b1, 5'd12, 32'h77, 32'h504);
    expw(5'd12, 32'h77, 32'h504);
    tick();
    pipe(1'b0, '0, '0, '0);
    chk("sup_busy_clr", busy, 32'h0);
    tick();
    tick();
    chk("sup_rf12", rf[12], 32'h77);

    // reset mid-flight
    issue(5'd9);
    issue(5'd10);
    pipe(1'b1, 5'd2, 32'h22, 32'h700);
    late(1'b1, 5'd9, 32'h999, 32'h800);
    expw(5'd2, 32'h22, 32'h700);
    tick();
    pipe(1'b1, 5'd2, 32'h23, 32'h704);
    late(1'b1, 5'd10, 32'hAAA, 32'h804);
    expw(5'd2, 32'h23, 32'h704);
    tick();
    pipe(1'b0, '0, '0, '0);
    late(1'b0, '0, '0, '0);
    chk("mid_busy", busy, 32'h0000_0600);
    chk("mid_full", {31'b0, l_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 32'h0);
    chk("mid_rst_we", {31'b0, WE}, 32'd0);
    chk("mid_rst_lready", {31'b0, l_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_after_busy", busy, 32'h0);

    // full queue: pop and offer in the same cycle is not accepted
    pipe(1'b1, 5'd2, 32'h1, 32'h900);
    late(1'b1, 5'd13, 32'hD13, 32'hA00);
    expw(5'd2, 32'h1, 32'h900);
    tick();
    pipe(1'b1, 5'd3, 32'h2, 32'h904);
    late(1'b1, 5'd14, 32'hD14, 32'hA04);
    expw(5'd3, 32'h2, 32'h904);
    tick();
    pipe(1'b0, '0, '0, '0);
    late(1'b1, 5'd15, 32'hD15, 32'hA08);
    chk("sim_full", {31'b0, l_ready}, 32'd0);
    expw(5'd13, 32'hD13, 32'hA00);
    tick();
    chk("sim_next", {31'b0, l_ready}, 32'd1);
    expw(5'd14, 32'hD14, 32'hA04);
    tick();
    late(1'b0, '0, '0, '0);
    expw(5'd15, 32'hD15, 32'hA08);
    tick();
    tick();

    // late write and issue to r0
    iss_valid = 1'b1; iss_wa = 5'd0;
    late(1'b1, 5'd0, 32'hF0, 32'hB00);
    chk("r0_lready", {31'b0, l_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    late(1'b0, '0, '0, '0);
    chk("r0_busy", busy, 32'h0);
    tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-back arbiter in front of the general register file's single write port. Merges in-order pipeline W-stage writes with out-of-order late writes (multi-cycle load/bus responses) through a small pending queue, drives the register file's write enable/address/data/PC, and exports a per-register busy mask to the hazard unit so that readers of not-yet-written registers stall.

## Interface
- DEPTH, 2, late-write queue entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- p_we  in  1  pipeline W-stage write request
- p_wa  in  5  pipeline write address
- p_wd  in  32  pipeline write data
- p_pc  in  32  pipeline instruction PC
- iss_valid  in  1  late-writing instruction issued this cycle (scoreboard set)
- iss_wa  in  5  destination of issued instruction
- l_valid  in  1  late write offered
- l_ready  out  1  late write accepted when l_valid && l_ready
- l_wa  in  5  late write address
- l_wd  in  32  late write data
- l_pc  in  32  late write PC
- WE  out  1  register file write enable
- WA  out  5  register file write address
- WD  out  32  register file write data
- PC  out  32  PC of the retiring write
- busy  out  32  bit r set while register r has an issued or queued, unretired late write; bit 0 always 0

## Operation
- Writes to register 0 never drive WE; they are consumed (pipeline) or accepted and discarded (late), and never set busy.
- Priority per cycle: pipeline write (p_we, p_wa≠0) > queue head > direct bypass of l_valid when queue empty.
- Queue: FIFO of {wa, wd, pc}; l_ready = !full; a late write is pushed when accepted and not bypassed. Push and pop in the same cycle allowed (count unchanged).
- Bypass: queue empty, no pipeline write, l_valid → WE/WA/WD/PC from l_*, accepted, not queued.
- Scoreboard: iss_valid && iss_wa≠0 sets busy[iss_wa]; busy[r] clears in the cycle the late write to r drives WE (set wins if issue and retire of same r coincide).
- WAW supersede: pipeline write to r while a queue entry targets r → that entry invalidated (popped without WE when reached) and busy[r] cleared; pipeline write is younger and wins.
- Late write accepted while busy[wa]=0 (orphan): still written, no error.

## Timing
- Outputs WE/WA/WD/PC, l_ready, busy are combinational from registered state and current inputs; pipeline write retires in the same cycle (zero latency), preserving register file write-through.
- Queued late write retires ≥1 cycle after acceptance; worst case bounded only by pipeline write traffic.
- Reset values: queue empty, count 0, busy = 0, WE=0, WA=0, WD=0, PC=0, l_ready=1.
- Reset mid-operation: queue contents and scoreboard dropped asynchronously; no WE until after rst_n deasserts.
- Full queue: l_ready=0 even if a pop occurs that cycle (no same-cycle pass-through when full).
- Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.

## Configuration
- GRF_WB_TRACE_EN defined: on every cycle with WE=1 at posedge clk, print "%d@%h: $%d <= %h" with $time, PC, WA, WD — the team's standard write trace; the register file's own trace must then be disabled to avoid duplicates.
- Undefined: no simulation output; RTL otherwise identical.

## Structure
- Package grf_wb_pkg: REG_AW=5, DATA_W=32, NREG=32, typedef wb_entry_t {wa, wd, pc, valid}.
- One sub-module wb_fifo (parameterized DEPTH, entry type, push/pop/full/empty, plus per-entry invalidate-by-address for supersede); arbitration and scoreboard stay in the top.

## Test plan
- Pipeline only: p_we=1, p_wa=5, p_wd=0x1234 → same cycle WE=1, WA=5, WD=0x1234; p_wa=0 → WE=0.
- Bypass: iss 8, then l_valid wa=8 wd=0xAA, idle pipeline → same cycle WE=1 WA=8; busy[8] 1→0 next cycle.
- Contention: pipeline writes 3 cycles, late writes wa=9,10 offered → queued, l_ready stays 1 then 0 when third offered; retire 9 then 10 after pipeline stops.
- Supersede: queued late write wa=12, then pipeline write wa=12 wd=0x77 → register 12 ends 0x77, queued entry produces no WE, busy[12]=0.
- Reset mid-flight: queue holds 2 entries, busy=0x600, pulse rst_n low → busy=0, WE=0, l_ready=1 immediately; no stale writes afterwards.
- Simultaneous: queue full, pop and l_valid in same cycle → not accepted; next cycle accepted.
